// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised oversampling UART receiver with read handshake
//
// Ports:
//   clk         system clock
//   arst_n      asynchronous active-low reset
//   rst         synchronous clear, same effect as reset
//   rx_en       allows new start bits to be accepted
//   BCLK        one-clk oversample tick, OVS ticks per bit period
//   rx_data     asynchronous serial line, idle high
//   rd          read strobe, consumes out
//   out         received word, LSB = first bit on the line
//   valid       out holds an unread word
//   done        one-clk pulse per completed frame
//   busy        frame reception in progress
//   parity_err  parity mismatch on the last completed frame
//   frame_err   a stop bit sampled low on the last completed frame
//   overrun     sticky: a frame completed while valid was set
module uart_rx_param #(
  parameter int DATA_W     = 8,
  parameter int OVS        = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              rst,
  input  logic              rx_en,
  input  logic              BCLK,
  input  logic              rx_data,
  input  logic              rd,
  output logic [DATA_W-1:0] out,
  output logic              valid,
  output logic              done,
  output logic              busy,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CNT_W = $clog2(OVS);
  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVS / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVS - 1);
  localparam logic [IDX_W-1:0] BIT_LAST  = IDX_W'(DATA_W - 1);
  localparam logic STOP_LAST = (STOP_BITS == 2);
  localparam logic HAS_PAR   = (PARITY_EN != 0);
  localparam logic ODD       = (PARITY_ODD != 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic              sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              stop_idx_q, stop_idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              perr_q, perr_d, ferr_q, ferr_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              perr_out_q, perr_out_d, ferr_out_q, ferr_out_d;
  logic              valid_q, valid_d, ovr_q, ovr_d;
  logic              rxs, cnt_full;

  assign rxs      = sync2_q;
  assign cnt_full = (cnt_q == FULL_LAST);

  always_comb begin
    sync1_d    = rx_data;
    sync2_d    = sync1_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    out_d      = out_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    valid_d    = valid_q;
    ovr_d      = ovr_q;

    if (BCLK) begin
      case (state_q)
        S_IDLE: begin
          if (rx_en && !rxs) begin
            state_d = S_START;
            cnt_d   = '0;
            busy_d  = 1'b1;
          end
        end
        S_START: begin
          if (cnt_q == HALF_LAST) begin
            if (rxs) begin
              // line went back high before mid start bit: a glitch, not a frame
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end else begin
              state_d = S_DATA;
              cnt_d   = '0;
              idx_d   = '0;
              perr_d  = 1'b0;
              ferr_d  = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt_full) begin
            cnt_d   = '0;
            shift_d = {rxs, shift_q[DATA_W-1:1]};
            idx_d   = idx_q + 1'b1;
            if (idx_q == BIT_LAST) begin
              state_d    = HAS_PAR ? S_PARITY : S_STOP;
              stop_idx_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_PARITY: begin
          if (cnt_full) begin
            cnt_d   = '0;
            perr_d  = ((^shift_q) ^ rxs) != ODD;
            state_d = S_STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt_full) begin
            cnt_d  = '0;
            ferr_d = ferr_q | ~rxs;
            if (stop_idx_q == STOP_LAST) begin
              // leave at mid stop bit so an immediately following start is caught
              state_d    = S_IDLE;
              busy_d     = 1'b0;
              done_d     = 1'b1;
              out_d      = shift_q;
              perr_out_d = perr_q;
              ferr_out_d = ferr_q | ~rxs;
            end else begin
              stop_idx_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end

    // A read coinciding with done consumes the old word; the new one stays valid.
    if (done_q) begin
      valid_d = 1'b1;
      if (valid_q && !rd) ovr_d = 1'b1;
    end else if (rd) begin
      valid_d = 1'b0;
    end

    if (rst) begin
      sync1_d    = 1'b1;
      sync2_d    = 1'b1;
      state_d    = S_IDLE;
      cnt_d      = '0;
      idx_d      = '0;
      stop_idx_d = 1'b0;
      shift_d    = '0;
      perr_d     = 1'b0;
      ferr_d     = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      out_d      = '0;
      perr_out_d = 1'b0;
      ferr_out_d = 1'b0;
      valid_d    = 1'b0;
      ovr_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      out_q      <= '0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      out_q      <= out_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
    end
  end

  assign out        = out_q;
  assign valid      = valid_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign parity_err = perr_out_q;
  assign frame_err  = ferr_out_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - scoreboard bench for uart_rx_param over three configurations
`timescale 1ns/1ps
module tb_uart_rx_param;

  logic clk = 1'b0, arst_n = 1'b0, rst = 1'b0, rx_en = 1'b1, BCLK = 1'b0;
  logic bclk_off = 1'b0;
  int unsigned div_cnt = 0;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    div_cnt++;
    BCLK = !bclk_off && (div_cnt % 2 == 0);
  end

  logic [2:0] rxl = 3'b111, rd_r = 3'b000, auto_rd = 3'b000, rd_w;
  logic [2:0] valid, done, busy, perr, ferr, ovr;
  logic [7:0] out0, out1;
  logic [4:0] out2;
  assign rd_w = rd_r | (auto_rd & done);

  // ch0: defaults; ch1: 8 bits even parity 2 stops; ch2: 5 bits OVS 8 odd parity
  uart_rx_param #(.DATA_W(8), .OVS(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .arst_n(arst_n), .rst(rst), .rx_en(rx_en), .BCLK(BCLK), .rx_data(rxl[0]),
    .rd(rd_w[0]), .out(out0), .valid(valid[0]), .done(done[0]), .busy(busy[0]),
    .parity_err(perr[0]), .frame_err(ferr[0]), .overrun(ovr[0]));
  uart_rx_param #(.DATA_W(8), .OVS(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u1 (
    .clk(clk), .arst_n(arst_n), .rst(rst), .rx_en(rx_en), .BCLK(BCLK), .rx_data(rxl[1]),
    .rd(rd_w[1]), .out(out1), .valid(valid[1]), .done(done[1]), .busy(busy[1]),
    .parity_err(perr[1]), .frame_err(ferr[1]), .overrun(ovr[1]));
  uart_rx_param #(.DATA_W(5), .OVS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
    .clk(clk), .arst_n(arst_n), .rst(rst), .rx_en(rx_en), .BCLK(BCLK), .rx_data(rxl[2]),
    .rd(rd_w[2]), .out(out2), .valid(valid[2]), .done(done[2]), .busy(busy[2]),
    .parity_err(perr[2]), .frame_err(ferr[2]), .overrun(ovr[2]));

  function automatic int cfg_dw(int c);   return (c == 2) ? 5 : 8;  endfunction
  function automatic int cfg_ovs(int c);  return (c == 2) ? 8 : 16; endfunction
  function automatic bit cfg_pen(int c);  return c != 0;            endfunction
  function automatic bit cfg_podd(int c); return c == 2;            endfunction
  function automatic int cfg_sb(int c);   return (c == 1) ? 2 : 1;  endfunction

  function automatic logic [8:0] outv(int c);
    case (c)
      0:       return {1'b0, out0};
      1:       return {1'b0, out1};
      default: return {4'b0, out2};
    endcase
  endfunction

  typedef struct {
    int         ch;
    logic [8:0] data;
    logic       pe;
    logic       fe;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  int n_cmp = 0, n_bad = 0;
  logic [2:0] mv = 3'b000, mo = 3'b000;

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s ch%0d: got %0h, expected %0h at %0t", name, c, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every done and tracks the valid/overrun rules.
  always @(negedge clk) begin
    for (int c = 0; c < 3; c++) begin
      if (!arst_n) begin
        mv[c] = 1'b0;
        mo[c] = 1'b0;
      end else begin
        chk("valid", c, 32'(valid[c]), 32'(mv[c]));
        chk("overrun", c, 32'(ovr[c]), 32'(mo[c]));
        if (done[c]) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", c, 32'(1), 32'(0));
          end else begin
            mon_e = exp_q.pop_front();
            chk("done_channel", c, 32'(c), 32'(mon_e.ch));
            chk("out", c, 32'(outv(c)), 32'(mon_e.data));
            chk("parity_err", c, 32'(perr[c]), 32'(mon_e.pe));
            chk("frame_err", c, 32'(ferr[c]), 32'(mon_e.fe));
          end
        end
        if (rst) begin
          mv[c] = 1'b0;
          mo[c] = 1'b0;
        end else if (done[c]) begin
          if (mv[c] && !rd_w[c]) mo[c] = 1'b1;
          mv[c] = 1'b1;
        end else if (rd_w[c]) begin
          mv[c] = 1'b0;
        end
      end
    end
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!BCLK) @(posedge clk);
    end
    #1;
  endtask

  task automatic drive_bit(input int c, input logic b, input int n);
    rxl[c] = b;
    wait_ticks(n);
  endtask

  function automatic logic good_parity(input int c, input logic [8:0] d);
    return (^d) ^ cfg_podd(c);
  endfunction

  task automatic send_frame(input int c, input logic [8:0] data, input logic pbit,
                            input logic [1:0] stop_mask, input bit push);
    int ovs = cfg_ovs(c);
    logic [8:0] d = data & 9'((1 << cfg_dw(c)) - 1);
    logic fe = !stop_mask[0] || (cfg_sb(c) == 2 && !stop_mask[1]);
    exp_t e;
    if (push) begin
      e.ch   = c;
      e.data = d;
      e.pe   = cfg_pen(c) && (((^d) ^ pbit) != cfg_podd(c));
      e.fe   = fe;
      exp_q.push_back(e);
    end
    drive_bit(c, 1'b0, ovs);
    for (int i = 0; i < cfg_dw(c); i++) drive_bit(c, d[i], ovs);
    if (cfg_pen(c)) drive_bit(c, pbit, ovs);
    for (int i = 0; i < cfg_sb(c); i++) drive_bit(c, stop_mask[i], ovs);
    rxl[c] = 1'b1;
    if (fe) wait_ticks(2 * ovs);
  endtask

  task automatic rd_pulse(input int c);
    @(posedge clk); #1 rd_r[c] = 1'b1;
    @(posedge clk); #1 rd_r[c] = 1'b0;
  endtask

  task automatic chk_zero(input string name);
    for (int c = 0; c < 3; c++)
      chk(name, c, 32'({outv(c), valid[c], done[c], busy[c], perr[c], ferr[c], ovr[c]}), 32'(0));
  endtask

  initial begin
    logic [8:0] d;
    logic [1:0] sm;
    repeat (3) @(negedge clk);
    chk_zero("reset_state");
    @(posedge clk); #1 arst_n = 1'b1;
    wait_ticks(4);

    // basic frame and read
    send_frame(0, 9'hA5, 1'b0, 2'b11, 1);
    wait_ticks(2);
    chk("a5_valid", 0, 32'(valid[0]), 32'(1));
    rd_pulse(0);
    #1 chk("a5_read_clears", 0, 32'(valid[0]), 32'(0));

    // 5-tick low glitch: false start
    drive_bit(0, 1'b0, 5);
    chk("glitch_busy", 0, 32'(busy[0]), 32'(1));
    drive_bit(0, 1'b1, 16);
    chk("glitch_busy_clear", 0, 32'(busy[0]), 32'(0));
    chk("glitch_no_valid", 0, 32'(valid[0]), 32'(0));

    // rx_en=0 blocks new starts; dropping it mid-frame does not abort
    rx_en = 1'b0;
    fork
      send_frame(0, 9'h3C, 1'b0, 2'b11, 0);
      begin wait_ticks(30); chk("rx_en_block", 0, 32'(busy[0]), 32'(0)); end
    join
    rx_en = 1'b1;
    wait_ticks(8);
    fork
      send_frame(0, 9'h5C, 1'b0, 2'b11, 1);
      begin wait_ticks(40); rx_en = 1'b0; end
    join
    rx_en = 1'b1;
    rd_pulse(0);

    // overrun, then read coinciding with done
    send_frame(0, 9'h11, 1'b0, 2'b11, 1);
    send_frame(0, 9'h22, 1'b0, 2'b11, 1);
    wait_ticks(2);
    chk("overrun_set", 0, 32'(ovr[0]), 32'(1));
    chk("overrun_out", 0, 32'(outv(0)), 32'h22);
    auto_rd[0] = 1'b1;
    send_frame(0, 9'h33, 1'b0, 2'b11, 1);
    auto_rd[0] = 1'b0;
    wait_ticks(2);
    chk("rd_with_done_valid", 0, 32'(valid[0]), 32'(1));
    chk("rd_with_done_out", 0, 32'(outv(0)), 32'h33);
    chk("rd_with_done_ovr", 0, 32'(ovr[0]), 32'(1));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("rst_clears_ovr", 0, 32'(ovr[0]), 32'(0));
    chk("rst_clears_valid", 0, 32'(valid[0]), 32'(0));

    // async reset mid-DATA abandons the frame
    d = 9'h5A;
    drive_bit(0, 1'b0, 16);
    for (int i = 0; i < 3; i++) drive_bit(0, d[i], 16);
    wait_ticks(5);
    arst_n = 1'b0;
    @(negedge clk);
    chk_zero("arst_mid_frame");
    repeat (2) @(posedge clk);
    #1 rxl[0] = 1'b1;
    arst_n = 1'b1;
    wait_ticks(32);
    send_frame(0, 9'h81, 1'b0, 2'b11, 1);
    rd_pulse(0);

    // parity (even) and two stop bits
    send_frame(1, 9'h07, 1'b1, 2'b11, 1);
    send_frame(1, 9'h07, 1'b0, 2'b11, 1);
    wait_ticks(2);
    chk("parity_bad_flag", 1, 32'(perr[1]), 32'(1));
    send_frame(1, 9'h3C, good_parity(1, 9'h3C), 2'b01, 1);
    chk("stop2_low_ferr", 1, 32'(ferr[1]), 32'(1));
    chk("stop2_low_out", 1, 32'(outv(1)), 32'h3C);
    rd_pulse(1);

    // 5-bit frames back to back, then a frame with the tick stream paused
    send_frame(2, 9'h15, good_parity(2, 9'h15), 2'b11, 1);
    send_frame(2, 9'h0A, good_parity(2, 9'h0A), 2'b11, 1);
    wait_ticks(2);
    chk("b2b_out", 2, 32'(outv(2)), 32'h0A);
    rd_pulse(2);
    fork
      send_frame(2, 9'h13, good_parity(2, 9'h13), 2'b11, 1);
      begin
        wait_ticks(30);
        bclk_off = 1'b1;
        repeat (60) @(posedge clk);
        chk("bclk_hold_busy", 2, 32'(busy[2]), 32'(1));
        bclk_off = 1'b0;
      end
    join
    rd_pulse(2);

    // randomized traffic on each configuration
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 18; k++) begin
        d  = 9'($urandom);
        sm = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
        send_frame(c, d, good_parity(c, d & 9'((1 << cfg_dw(c)) - 1)) ^ ($urandom_range(0, 3) == 0),
                   sm, 1);
        if ($urandom_range(0, 1) == 1) rd_pulse(c);
        wait_ticks($urandom_range(0, cfg_ovs(c)));
      end
    end

    wait_ticks(64);
    chk("scoreboard_drained", 0, 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #950000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached, %0d frames outstanding", exp_q.size());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
